// File: rtl/mul_seq_32.sv
// mul_seq_32: iterative shift-and-add multiplier for RV32M MUL/MULH/MULHSU/MULHU.
// Operands are reduced to magnitudes, multiplied over 32 shift-add steps, and the
// 64-bit product is conditionally negated before the requested half is returned.
// One 32-bit ripple-carry adder is shared by every step.
// Ports:
//   clk    - clock, rising edge
//   rst    - synchronous reset, active-high
//   start  - request, sampled only while busy=0
//   op     - 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
//   rs1    - multiplicand operand
//   rs2    - multiplier operand
//   busy   - operation in flight
//   valid  - one-cycle pulse, result valid
//   result - selected product half, held until the next valid
module mul_seq_32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  output logic        busy,
  output logic        valid,
  output logic [31:0] result
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE, S_ABS, S_MUL, S_FIX_LO, S_FIX_HI, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        op_q, op_d;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [XLEN-1:0]   p_hi_q, p_hi_d;
  logic [XLEN-1:0]   m_lo_q, m_lo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  logic [XLEN-1:0]   add_a, add_b, add_sum;
  logic              add_cin, add_cout;

  // Shared adder operand select; depends only on state and registered/input values.
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    case (state_q)
      // rs2 magnitude is formed while accepting, the adder is otherwise idle here
      S_IDLE, S_DONE: begin
        add_a   = ~rs2;
        add_cin = 1'b1;
      end
      S_ABS: begin
        add_a   = ~mcand_q;
        add_cin = 1'b1;
      end
      S_MUL: begin
        add_a = p_hi_q;
        add_b = m_lo_q[0] ? mcand_q : '0;
      end
      S_FIX_LO: begin
        add_a   = ~m_lo_q;
        add_cin = 1'b1;
      end
      S_FIX_HI: begin
        add_a   = ~p_hi_q;
        add_cin = carry_q;
      end
      default: ;
    endcase
  end

  // 32-bit ripple-carry adder
  always_comb begin
    logic c;
    add_sum = '0;
    c       = add_cin;
    for (int i = 0; i < 32; i++) begin
      add_sum[i] = add_a[i] ^ add_b[i] ^ c;
      c          = (add_a[i] & add_b[i]) | (c & (add_a[i] ^ add_b[i]));
    end
    add_cout = c;
  end

  // Next-state and datapath updates
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    p_hi_d   = p_hi_q;
    m_lo_d   = m_lo_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    result_d = result_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d    = op;
          mcand_d = rs1;
          m_lo_d  = (!op[1] && rs2[31]) ? add_sum : rs2;
          neg_d   = ((op != 2'b11) && rs1[31]) ^ (!op[1] && rs2[31]);
          p_hi_d  = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_ABS;
        end
      end
      S_ABS: begin
        if ((op_q != 2'b11) && mcand_q[31]) mcand_d = add_sum;
        state_d = S_MUL;
      end
      S_MUL: begin
        // {P_hi, M_lo} <= {sum33, M_lo[31:1]}
        p_hi_d = {add_cout, add_sum[XLEN-1:1]};
        m_lo_d = {add_sum[0], m_lo_q[XLEN-1:1]};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(31)) state_d = S_FIX_LO;
      end
      S_FIX_LO: begin
        if (neg_q) begin
          m_lo_d  = add_sum;
          carry_d = add_cout;
        end
        state_d = S_FIX_HI;
      end
      S_FIX_HI: begin
        if (neg_q) p_hi_d = add_sum;
        // result is registered on entry to DONE so it is live in the valid cycle
        result_d = (op_q == 2'b00) ? m_lo_q : (neg_q ? add_sum : p_hi_q);
        busy_d   = 1'b0;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      p_hi_q   <= '0;
      m_lo_q   <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      p_hi_q   <= p_hi_d;
      m_lo_q   <= m_lo_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_seq_32.sv
// Testbench for mul_seq_32: a cycle-level behavioural model (accept/latency rules
// plus a wide-integer product) checked against the DUT every cycle, together with
// directed cases carrying hand-computed expectations.
module tb_mul_seq_32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] rs1, rs2;
  logic        busy, valid;
  logic [31:0] result;

  int vectors     = 0;
  int miscompares = 0;

  mul_seq_32 dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1(rs1), .rs2(rs2),
    .busy(busy), .valid(valid), .result(result)
  );

  always #5 clk = ~clk;

  // Reference product: extend operands by signedness and take the requested half
  function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [127:0] x, y, p;
    x = (o != 2'b11) ? {{96{a[31]}}, a} : {96'b0, a};
    y = (o[1] == 1'b0) ? {{96{b[31]}}, b} : {96'b0, b};
    p = x * y;
    return (o == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  // Behavioural model: accept when idle, valid 35 edges later, result held
  bit          m_init = 1'b0;
  logic        m_busy, m_valid;
  logic [31:0] m_result, m_exp;
  int          m_left;

  always @(posedge clk) begin
    if (rst) begin
      m_init   <= 1'b1;
      m_busy   <= 1'b0;
      m_valid  <= 1'b0;
      m_result <= '0;
      m_left   <= 0;
    end else if (m_init) begin
      m_valid <= 1'b0;
      if (!m_busy && start) begin
        m_busy <= 1'b1;
        m_left <= 35;
        m_exp  <= ref_mul(op, rs1, rs2);
      end else if (m_busy) begin
        if (m_left == 1) begin
          m_busy   <= 1'b0;
          m_valid  <= 1'b1;
          m_result <= m_exp;
        end
        m_left <= m_left - 1;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (m_init) begin
      vectors++;
      if (busy !== m_busy || valid !== m_valid || result !== m_result) begin
        miscompares++;
        $display("FAIL cycle_check t=%0t busy=%b/%b valid=%b/%b result=%h/%h (dut/model)",
                 $time, busy, m_busy, valid, m_valid, result, m_result);
      end
    end
  end

  task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, act, exp);
    end
  endtask

  // Wait for valid after an accepted start; returns edges counted since acceptance
  task automatic wait_valid(output int k);
    k = 0;
    while (k < 60 && valid !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input string name);
    int k;
    @(negedge clk);
    start = 1'b1; op = o; rs1 = a; rs2 = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    wait_valid(k);
    check_eq({name, " latency"}, 32'(k), 32'd35);
    check_eq(name, result, exp);
    check_eq({name, " busy"}, 32'(busy), 32'd0);
  endtask

  logic [31:0] corners [8] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000,
                               32'h7FFFFFFF, 32'h2, 32'hFFFFFFFE, 32'h80000001};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 7)];
    return $urandom;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int k, nv;
    logic [1:0] o;
    logic [31:0] a, b;
    rst = 1'b1; start = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(busy), 32'd0);
    check_eq("reset valid", 32'(valid), 32'd0);
    check_eq("reset result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Hand-computed products
    run_op(2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, "mul 7x-3");
    run_op(2'b01, 32'h80000000, 32'h80000000, 32'h40000000, "mulh min*min");
    run_op(2'b00, 32'h80000000, 32'h80000000, 32'h00000000, "mul min*min");
    run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu -1*max");
    run_op(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu max*max");
    run_op(2'b01, 32'hFFFFFFFB, 32'h0, 32'h00000000, "mulh -5*0");

    // start held high with changing operands: only the first request counts
    @(negedge clk);
    start = 1'b1; op = 2'b00; rs1 = 32'd1000; rs2 = 32'hFFFFFFFE;
    @(posedge clk);
    repeat (30) begin
      @(negedge clk);
      op = 2'($urandom); rs1 = $urandom; rs2 = $urandom;
    end
    @(negedge clk);
    start = 1'b0;
    wait_valid(k);
    check_eq("held start result", result, 32'hFFFFF830);
    nv = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nv++;
    end
    check_eq("held start single valid", 32'(nv), 32'd0);

    // Back-to-back: start asserted in the DONE cycle
    run_op(2'b11, 32'd9, 32'd9, 32'd0, "b2b first mulhu");
    start = 1'b1; op = 2'b00; rs1 = 32'd6; rs2 = 32'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    k = 1;
    while (k < 60 && valid !== 1'b1) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("b2b valid spacing", 32'(k), 32'd36);
    check_eq("b2b result", result, 32'd42);

    // Reset ten cycles into an operation
    @(negedge clk);
    start = 1'b1; op = 2'b11; rs1 = 32'h12345678; rs2 = 32'h9ABCDEF0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort busy", 32'(busy), 32'd0);
    check_eq("abort valid", 32'(valid), 32'd0);
    check_eq("abort result", result, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    nv = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (valid === 1'b1) nv++;
    end
    check_eq("abort no valid", 32'(nv), 32'd0);
    run_op(2'b00, 32'd3, 32'd5, 32'd15, "after abort 3x5");

    // Randomized operations with random gaps
    for (int i = 0; i < 300; i++) begin
      o = 2'($urandom);
      a = pick();
      b = pick();
      run_op(o, a, b, ref_mul(o, a, b), "random");
      repeat ($urandom_range(0, 3)) @(posedge clk);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
